// File: rtl/regset_pkg.sv
// Shared types for the regset_sb register set: word/regnum, the sweep FSM states, port limits.
// REGISTER_COUNT may be predefined by the build; it falls back to 32 architectural registers.
`ifndef REGISTER_COUNT
`define REGISTER_COUNT 32
`endif

package regset_pkg;
    localparam int WORD_W                = 32;
    localparam int REGSET_MAX_READ_PORTS = 4;
    localparam int REGSET_DEFAULT_COUNT  = `REGISTER_COUNT;

    typedef logic [WORD_W-1:0]                       word;
    typedef logic [$clog2(REGSET_DEFAULT_COUNT)-1:0] regnum;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } regset_state_e;
endpackage

// File: rtl/regset_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback or flush.
// busy_count is the registered popcount of the pending vector, updated on the same edge.
module regset_sb_scoreboard
    import regset_pkg::*;
#(
    parameter int RegisterCount = `REGISTER_COUNT,
    parameter int CountW        = $clog2(RegisterCount) + 1
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     en,
    input  logic                     issue_en,
    input  regnum                    issue_reg,
    input  logic                     wr_en,
    input  regnum                    wr_reg,
    input  logic                     flush,
    output logic [RegisterCount-1:0] pending,
    output logic [CountW-1:0]        busy_count
);
    localparam int IdxW = $clog2(RegisterCount);

    logic [RegisterCount-1:0] pending_d;
    logic [CountW-1:0]        count_d;

    // Order matters: flush, then writeback clear, then issue set, so issue wins collisions.
    always_comb begin
        pending_d = pending;
        if (en) begin
            if (flush)
                pending_d = '0;
            if (wr_en && wr_reg != '0)
                pending_d[wr_reg[IdxW-1:0]] = 1'b0;
            if (issue_en && issue_reg != '0)
                pending_d[issue_reg[IdxW-1:0]] = 1'b1;
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < RegisterCount; i++)
            count_d = count_d + CountW'(pending_d[i]);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pending    <= '0;
            busy_count <= '0;
        end else begin
            pending    <= pending_d;
            busy_count <= count_d;
        end
    end
endmodule

// File: rtl/regset_sb.sv
// Register set with N read ports, pending-write scoreboard and a post-reset clear sweep.
// Defining REGSET_BYPASS_EN forwards same-cycle writeback data to matching read ports.
module regset_sb
    import regset_pkg::*;
#(
    parameter int RegisterCount = `REGISTER_COUNT,
    parameter int ReadPorts     = 2
) (
    input  logic                             clk,
    input  logic                             res,
    input  regnum                            rd_reg     [ReadPorts],
    output word                              rd_data    [ReadPorts],
    output logic                             rd_busy    [ReadPorts],
    input  logic                             wr_en,
    input  regnum                            wr_reg,
    input  word                              wr_data,
    input  logic                             issue_en,
    input  regnum                            issue_reg,
    input  logic                             flush,
    output logic                             ready,
    output logic [$clog2(RegisterCount):0]   busy_count,
    output regset_state_e                    dbg_state
);
    localparam int IdxW = $clog2(RegisterCount);

    regset_state_e            state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [RegisterCount-1:0] pending;
    word                      regs [1:RegisterCount-1];

    assign ready     = (state_q == READY);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= INIT;
            idx_q   <= IdxW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == INIT) begin
            idx_d = idx_q + IdxW'(1);
            if (idx_q == IdxW'(RegisterCount - 1))
                state_d = READY;
        end
    end

    // Storage has no reset; the sweep rewrites every entry before ready rises.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            regs[idx_q] <= '0;
        else if (wr_en && wr_reg != '0)
            regs[wr_reg[IdxW-1:0]] <= wr_data;
    end

    regset_sb_scoreboard #(
        .RegisterCount(RegisterCount)
    ) u_scoreboard (
        .clk       (clk),
        .res       (res),
        .en        (ready),
        .issue_en  (issue_en),
        .issue_reg (issue_reg),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .flush     (flush),
        .pending   (pending),
        .busy_count(busy_count)
    );

    always_comb begin
        for (int p = 0; p < ReadPorts; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (ready && rd_reg[p] != '0) begin
                rd_data[p] = regs[rd_reg[p][IdxW-1:0]];
                rd_busy[p] = pending[rd_reg[p][IdxW-1:0]];
`ifdef REGSET_BYPASS_EN
                if (wr_en && wr_reg != '0 && rd_reg[p] == wr_reg) begin
                    rd_data[p] = wr_data;
                    rd_busy[p] = issue_en && (issue_reg == wr_reg);
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_regset_sb.sv
// Directed bench for regset_sb: reset sweep, writes, scoreboard/flush, collisions, bypass, mid-run reset.
module tb_regset_sb;
    import regset_pkg::*;

    logic          clk;
    logic          res;
    regnum         rd_reg  [2];
    word           rd_data [2];
    logic          rd_busy [2];
    logic          wr_en;
    regnum         wr_reg;
    word           wr_data;
    logic          issue_en;
    regnum         issue_reg;
    logic          flush;
    logic          ready;
    logic [5:0]    busy_count;
    regset_state_e dbg_state;

    int tests;
    int fails;
    int edges;

    regset_sb #(.RegisterCount(32), .ReadPorts(2)) dut (
        .clk       (clk),
        .res       (res),
        .rd_reg    (rd_reg),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_reg (issue_reg),
        .flush     (flush),
        .ready     (ready),
        .busy_count(busy_count),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle just past it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    endtask

    // Count edges until ready rises, bounded so a stuck sweep still reaches the summary.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        res = 1'b1;
        rd_reg[0] = '0; rd_reg[1] = '0;
        wr_reg = '0; wr_data = '0; issue_reg = '0;
        idle();

        // Reset state and sweep length
        repeat (3) @(posedge clk);
        #1;
        rd_reg[0] = 5'd5;
        #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_busy_count", 32'(busy_count), 32'd0);
        check("reset_rd_data", rd_data[0], 32'd0);
        check("reset_rd_busy", 32'(rd_busy[0]), 32'd0);
        res = 1'b0;
        wait_ready(edges);
        check("sweep_edges", 32'(edges), 32'd31);
        check("sweep_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 32; i++) begin
            rd_reg[0] = regnum'(i);
            rd_reg[1] = regnum'(31 - i);
            #1;
            check($sformatf("sweep_zero_p0_x%0d", i), rd_data[0], 32'd0);
            check($sformatf("sweep_zero_p1_x%0d", 31 - i), rd_data[1], 32'd0);
        end

        // Basic write and x0
        rd_reg[0] = 5'd5; rd_reg[1] = 5'd0;
        wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
`ifdef REGSET_BYPASS_EN
        check("write_same_cycle_bypass", rd_data[0], 32'hDEADBEEF);
`else
        check("write_same_cycle_old", rd_data[0], 32'd0);
`endif
        step();
        idle();
        check("write_x5", rd_data[0], 32'hDEADBEEF);
        check("read_x0", rd_data[1], 32'd0);
        wr_en = 1'b1; wr_reg = 5'd0; wr_data = 32'h1;
        step();
        idle();
        check("write_x0_ignored", rd_data[1], 32'd0);

        // Scoreboard: duplicate issue, writeback clear, flush with issue
        issue_en = 1'b1; issue_reg = 5'd7; step();
        issue_reg = 5'd9; step();
        issue_reg = 5'd7; step();
        idle();
        rd_reg[0] = 5'd7; rd_reg[1] = 5'd9;
        #1;
        check("dup_issue_count", 32'(busy_count), 32'd2);
        check("busy_x7", 32'(rd_busy[0]), 32'd1);
        check("busy_x9", 32'(rd_busy[1]), 32'd1);
        wr_en = 1'b1; wr_reg = 5'd7; wr_data = 32'h77;
        step();
        idle();
        check("wb_count", 32'(busy_count), 32'd1);
        check("wb_x7_not_busy", 32'(rd_busy[0]), 32'd0);
        check("wb_x7_data", rd_data[0], 32'h77);
        flush = 1'b1; issue_en = 1'b1; issue_reg = 5'd3;
        step();
        idle();
        rd_reg[0] = 5'd3;
        #1;
        check("flush_count", 32'(busy_count), 32'd1);
        check("flush_x3_busy", 32'(rd_busy[0]), 32'd1);
        check("flush_x9_clear", 32'(rd_busy[1]), 32'd0);

        // Issue and write to the same register: data stored, pending stays set
        issue_en = 1'b1; issue_reg = 5'd4;
        wr_en = 1'b1; wr_reg = 5'd4; wr_data = 32'h55;
        step();
        idle();
        rd_reg[0] = 5'd4;
        #1;
        check("collide_data", rd_data[0], 32'h55);
        check("collide_busy", 32'(rd_busy[0]), 32'd1);
        check("collide_count", 32'(busy_count), 32'd2);

        // Bypass window on port 1
        rd_reg[1] = 5'd6;
        wr_en = 1'b1; wr_reg = 5'd6; wr_data = 32'h1234;
        #1;
`ifdef REGSET_BYPASS_EN
        check("bypass_same_cycle", rd_data[1], 32'h1234);
`else
        check("no_bypass_old_value", rd_data[1], 32'd0);
`endif
        check("bypass_busy", 32'(rd_busy[1]), 32'd0);
        step();
        idle();
        check("bypass_next_cycle", rd_data[1], 32'h1234);

        // Mid-operation asynchronous reset
        issue_en = 1'b1; issue_reg = 5'd10; step();
        issue_reg = 5'd11; step();
        issue_reg = 5'd12; step();
        idle();
        check("pre_reset_count", 32'(busy_count), 32'd5);
        rd_reg[0] = 5'd5;
        #2;
        res = 1'b1;
        #1;
        check("async_ready_drop", 32'(ready), 32'd0);
        check("async_count_clear", 32'(busy_count), 32'd0);
        check("async_rd_data", rd_data[0], 32'd0);
        step();
        res = 1'b0;
        wr_en = 1'b1; wr_reg = 5'd10; wr_data = 32'hCAFE;
        issue_en = 1'b1; issue_reg = 5'd11;
        flush = 1'b1;
        wait_ready(edges);
        idle();
        check("resweep_edges", 32'(edges), 32'd31);
        rd_reg[0] = 5'd10; rd_reg[1] = 5'd11;
        #1;
        check("init_write_ignored", rd_data[0], 32'd0);
        check("init_issue_ignored", 32'(rd_busy[1]), 32'd0);
        check("resweep_count", 32'(busy_count), 32'd0);
        rd_reg[0] = 5'd5;
        #1;
        check("resweep_x5_cleared", rd_data[0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
